// File: rtl/p_s_pkg.sv
// ----------------------------------------------------------------------------
// p_s_pkg
// Shared definitions for the p_s_param parallel-to-serial converter:
//   - frame ordering mode encodings
//   - clog2 helper that never returns less than 1, so index vectors are
//     always at least one bit wide even for degenerate sizes
// ----------------------------------------------------------------------------
package p_s_pkg;

    // Frame ordering, latched per frame from in_mode on its first beat.
    localparam logic ORD_BEAT_MAJOR = 1'b0;   // beat 0 lanes 0..L-1, beat 1 ...
    localparam logic ORD_LANE_MAJOR = 1'b1;   // lane 0 beats 0..B-1, lane 1 ...

    // Ceiling log2 with a floor of 1.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage : p_s_pkg

// File: rtl/p_s_bank.sv
// ----------------------------------------------------------------------------
// p_s_bank
// One ping-pong bank: LANES*BEATS words of storage plus the frame's order
// mode bit.
//
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (mode bit only)
//   wr_en    in  write one full beat this cycle
//   wr_beat  in  beat position being written
//   wr_data  in  LANES*W beat, lane l at [l*W +: W]
//   wr_mode  in  order mode, captured when beat 0 is written
//   rd_idx   in  serial word index within the frame
//   rd_word  out word at rd_idx after applying the bank's order mode
// ----------------------------------------------------------------------------
module p_s_bank
    import p_s_pkg::*;
#(
    parameter int W     = 34,
    parameter int LANES = 4,
    parameter int BEATS = 4,
    parameter int IW    = clog2_min1(LANES * BEATS),
    parameter int BW    = clog2_min1(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [BW-1:0]        wr_beat,
    input  logic [LANES*W-1:0]   wr_data,
    input  logic                 wr_mode,
    input  logic [IW-1:0]        rd_idx,
    output logic [W-1:0]         rd_word
);

    localparam int LW    = clog2_min1(LANES);
    localparam int LOG_L = $clog2(LANES);
    localparam int LOG_B = $clog2(BEATS);

    logic               mode_reg;
    logic [BW-1:0]      rd_beat;
    logic [LW-1:0]      rd_lane;
    logic [W-1:0]       lane_word [LANES];

    // The mode bit belongs to the frame, so it is taken with beat 0 only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= ORD_BEAT_MAJOR;
        end else if (wr_en && (wr_beat == '0)) begin
            mode_reg <= wr_mode;
        end
    end

    // One storage column per lane; a whole beat lands in every column at once.
    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [W-1:0] mem [BEATS];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_beat] <= wr_data[gi*W +: W];
            end
        end

        assign lane_word[gi] = mem[rd_beat];
    end

    // LANES and BEATS are powers of two, so div/mod reduce to shift/mask.
    always_comb begin
        rd_beat = '0;
        rd_lane = '0;
        if (mode_reg == ORD_BEAT_MAJOR) begin
            rd_beat = BW'(rd_idx >> LOG_L);
            rd_lane = LW'(rd_idx & IW'(LANES - 1));
        end else begin
            rd_lane = LW'(rd_idx >> LOG_B);
            rd_beat = BW'(rd_idx & IW'(BEATS - 1));
        end
    end

    assign rd_word = lane_word[rd_lane];

endmodule : p_s_bank

// File: rtl/p_s_param.sv
// ----------------------------------------------------------------------------
// p_s_param
// Double-buffered parallel-to-serial converter. Frames of BEATS beats, each
// LANES words of W bits, are collected into one of two banks and replayed one
// word per accepted output cycle, in beat-major or lane-major order chosen
// per frame.
//
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   clr        in  synchronous clear, drops every buffered frame
//   in_valid   in  input beat valid
//   in_ready   out a beat can be accepted (write bank not full)
//   in_data    in  beat, lane l at [l*W +: W]
//   in_mode    in  frame order, sampled on the first beat of a frame
//   out_valid  out out_data holds a valid word (read bank full)
//   out_ready  in  downstream accepts the word
//   out_data   out serial word, zero when out_valid is low
//   out_first  out word is index 0 of its frame
//   out_last   out word is index N-1 of its frame
// ----------------------------------------------------------------------------
module p_s_param
    import p_s_pkg::*;
#(
    parameter int W     = 34,
    parameter int LANES = 4,
    parameter int BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_first,
    output logic                 out_last
);

    localparam int N  = LANES * BEATS;
    localparam int IW = clog2_min1(N);
    localparam int BW = clog2_min1(BEATS);

    logic [1:0]     full_reg,    full_next;
    logic           wr_bank_reg, wr_bank_next;
    logic           rd_bank_reg, rd_bank_next;
    logic [BW-1:0]  wr_beat_reg, wr_beat_next;
    logic [IW-1:0]  rd_idx_reg,  rd_idx_next;

    logic           wr_fire;
    logic           rd_fire;
    logic           wr_last;
    logic           rd_last;
    logic [W-1:0]   bank_word [2];

    assign in_ready  = !full_reg[wr_bank_reg];
    assign out_valid = full_reg[rd_bank_reg];

    // clr wins over both handshakes, even though in_ready may read high.
    assign wr_fire = in_valid && in_ready && !clr;
    assign rd_fire = out_valid && out_ready && !clr;

    assign wr_last = (wr_beat_reg == BW'(BEATS - 1));
    assign rd_last = (rd_idx_reg == IW'(N - 1));

    // The last write and the last read of the same cycle always hit
    // different banks, so both full-flag updates can apply together.
    always_comb begin
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        wr_beat_next = wr_beat_reg;
        rd_idx_next  = rd_idx_reg;

        if (clr) begin
            full_next    = '0;
            wr_bank_next = 1'b0;
            rd_bank_next = 1'b0;
            wr_beat_next = '0;
            rd_idx_next  = '0;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    wr_beat_next           = '0;
                    full_next[wr_bank_reg] = 1'b1;
                    wr_bank_next           = !wr_bank_reg;
                end else begin
                    wr_beat_next = wr_beat_reg + BW'(1);
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    rd_idx_next            = '0;
                    full_next[rd_bank_reg] = 1'b0;
                    rd_bank_next           = !rd_bank_reg;
                end else begin
                    rd_idx_next = rd_idx_reg + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_beat_reg <= '0;
            rd_idx_reg  <= '0;
        end else begin
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            wr_beat_reg <= wr_beat_next;
            rd_idx_reg  <= rd_idx_next;
        end
    end

    // Both banks see the same read index; only the rd_bank word is used.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_bank
        p_s_bank #(
            .W     (W),
            .LANES (LANES),
            .BEATS (BEATS),
            .IW    (IW),
            .BW    (BW)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_fire && (wr_bank_reg == 1'(gi))),
            .wr_beat (wr_beat_reg),
            .wr_data (in_data),
            .wr_mode (in_mode),
            .rd_idx  (rd_idx_reg),
            .rd_word (bank_word[gi])
        );
    end

    assign out_data  = out_valid ? bank_word[rd_bank_reg] : '0;
    assign out_first = out_valid && (rd_idx_reg == '0);
    assign out_last  = out_valid && rd_last;

endmodule : p_s_param

// File: tb/tb_p_s_param.sv
// ----------------------------------------------------------------------------
// tb_p_s_param
// Two converters: A with W=34, LANES=4, BEATS=4 and B with W=8, LANES=2,
// BEATS=8 (both N=16). Stimulus tasks push the expected word stream for a
// frame into a per-instance queue once its last beat is accepted; a monitor
// per instance pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_p_s_param;

    localparam int AL = 4, AB = 4;
    localparam int BL = 2, BB = 8;
    localparam int NW = 16;

    typedef struct {
        logic [33:0] d;
        logic        f;
        logic        l;
        int          k;
    } exp_t;

    logic         clk;
    logic         a_rst_n, a_clr, a_in_valid, a_in_ready, a_in_mode;
    logic         a_out_valid, a_out_ready, a_out_first, a_out_last;
    logic [135:0] a_in_data;
    logic [33:0]  a_out_data;
    logic         b_rst_n, b_clr, b_in_valid, b_in_ready, b_in_mode;
    logic         b_out_valid, b_out_ready, b_out_first, b_out_last;
    logic [15:0]  b_in_data;
    logic [7:0]   b_out_data;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;
    int   a_pops = 0;
    int   b_pops = 0;
    int   a_rdy_mode = 1;
    int   b_rdy_mode = 1;
    int   last_first_pops = 0;

    p_s_param #(.W(34), .LANES(AL), .BEATS(AB)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .clr(a_clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_first(a_out_first), .out_last(a_out_last)
    );

    p_s_param #(.W(8), .LANES(BL), .BEATS(BB)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_first(b_out_first), .out_last(b_out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic check_word(input string name, input logic [33:0] act, input logic [33:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic in_rdy(input int dut);
        return (dut == 0) ? a_in_ready : b_in_ready;
    endfunction
    function automatic logic o_valid(input int dut);
        return (dut == 0) ? a_out_valid : b_out_valid;
    endfunction
    function automatic logic o_first(input int dut);
        return (dut == 0) ? a_out_first : b_out_first;
    endfunction
    function automatic logic o_last(input int dut);
        return (dut == 0) ? a_out_last : b_out_last;
    endfunction
    function automatic logic [33:0] o_data(input int dut);
        return (dut == 0) ? a_out_data : 34'(b_out_data);
    endfunction
    function automatic int pops(input int dut);
        return (dut == 0) ? a_pops : b_pops;
    endfunction
    function automatic int qsize(input int dut);
        return (dut == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic rand_words(input int dut, output logic [33:0] w [NW]);
        for (int i = 0; i < NW; i++) begin
            w[i] = 34'({$urandom(), $urandom()});
            if (dut != 0) w[i] = w[i] & 34'hFF;
        end
    endtask

    task automatic drive_beat(input int dut, input logic v, input logic [33:0] w [NW],
                              input int beat, input logic mode);
        if (dut == 0) begin
            a_in_valid = v;
            a_in_mode  = mode;
            for (int l = 0; l < AL; l++) a_in_data[l*34 +: 34] = w[beat*AL + l];
        end else begin
            b_in_valid = v;
            b_in_mode  = mode;
            for (int l = 0; l < BL; l++) b_in_data[l*8 +: 8] = w[beat*BL + l][7:0];
        end
    endtask

    // Reference order: word k of the frame, from the mode's beat/lane rule.
    task automatic push_expected(input int dut, input logic [33:0] w [NW], input logic mode);
        int   nl, nb, bt, ln;
        exp_t e;
        nl = (dut == 0) ? AL : BL;
        nb = (dut == 0) ? AB : BB;
        for (int k = 0; k < NW; k++) begin
            if (mode == 1'b0) begin
                bt = k / nl;
                ln = k % nl;
            end else begin
                ln = k / nb;
                bt = k % nb;
            end
            e.d = (dut == 0) ? w[bt*nl + ln] : 34'(w[bt*nl + ln][7:0]);
            e.f = (k == 0);
            e.l = (k == NW - 1);
            e.k = k;
            if (dut == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
    endtask

    // Presents one beat until accepted; returns at posedge+1 of acceptance.
    task automatic send_beat(input int dut, input logic [33:0] w [NW], input int beat,
                             input logic mode, output logic ok);
        logic rdy;
        ok = 1'b0;
        drive_beat(dut, 1'b1, w, beat, mode);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            rdy = in_rdy(dut);
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (dut == 0) a_in_valid = 1'b0;
        else          b_in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_accept dut=%0d beat=%0d actual=not_accepted required=accepted", dut, beat);
        end
    endtask

    task automatic send_frame(input int dut, input logic [33:0] w [NW], input logic mode);
        int   nb;
        logic ok;
        nb = (dut == 0) ? AB : BB;
        for (int b = 0; b < nb; b++) begin
            send_beat(dut, w, b, mode, ok);
            if (!ok) return;
            if (b == 0) last_first_pops = pops(dut);
        end
        push_expected(dut, w, mode);
        $display("%s frame stored mode=%0d", (dut == 0) ? "A" : "B", mode);
    endtask

    task automatic wait_drain(input int dut);
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #3;
            if (qsize(dut) == 0 && !o_valid(dut)) return;
        end
        total++;
        bad++;
        $display("FAIL drain dut=%0d actual=pending=%0d required=pending=0", dut, qsize(dut));
    endtask

    task automatic set_ready_low(input int dut);
        if (dut == 0) begin
            a_rdy_mode  = 0;
            a_out_ready = 1'b0;
        end else begin
            b_rdy_mode  = 0;
            b_out_ready = 1'b0;
        end
    endtask

    // Drain a frame up to word 7, hold it, pull reset, then prove recovery.
    task automatic reset_mid_drain(input int dut, input logic mode);
        logic [33:0] w [NW];
        int          base;
        logic        found;
        rand_words(dut, w);
        base = pops(dut);
        send_frame(dut, w, mode);
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #2;
            if (pops(dut) - base >= 7) begin
                found = 1'b1;
                break;
            end
        end
        check_bit("rst_reach_word7", found, 1'b1);
        set_ready_low(dut);
        if (found && qsize(dut) > 0) begin
            check_word("rst_word7_data", o_data(dut), (dut == 0) ? q_a[0].d : q_b[0].d);
            check_bit("rst_word7_first", o_first(dut), 1'b0);
        end
        #1;
        if (dut == 0) a_rst_n = 1'b0;
        else          b_rst_n = 1'b0;
        #1;
        check_bit("rst_async_valid", o_valid(dut), 1'b0);
        check_bit("rst_async_first", o_first(dut), 1'b0);
        check_bit("rst_async_last", o_last(dut), 1'b0);
        check_word("rst_async_data", o_data(dut), 34'd0);
        check_bit("rst_async_in_ready", in_rdy(dut), 1'b1);
        if (dut == 0) q_a.delete();
        else          q_b.delete();
        @(posedge clk);
        #2;
        if (dut == 0) begin
            a_rst_n    = 1'b1;
            a_rdy_mode = 1;
        end else begin
            b_rst_n    = 1'b1;
            b_rdy_mode = 1;
        end
        rand_words(dut, w);
        send_frame(dut, w, mode);
        wait_drain(dut);
    endtask

    // ---------------- out_ready generators ----------------
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (a_rdy_mode)
                0:       a_out_ready = 1'b0;
                1:       a_out_ready = 1'b1;
                default: a_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (b_rdy_mode)
                0:       b_out_ready = 1'b0;
                1:       b_out_ready = 1'b1;
                default: b_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitors ----------------
    initial begin : mon_a
        logic        hold;
        logic [33:0] hold_d;
        exp_t        e;
        hold   = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!a_rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check_bit("a_hold_valid", a_out_valid, 1'b1);
                    check_word("a_hold_data", a_out_data, hold_d);
                end
                if (a_out_valid && a_out_ready) begin
                    if (q_a.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL a_extra_word actual=%0h required=no_word", a_out_data);
                    end else begin
                        e = q_a.pop_front();
                        check_word("a_data", a_out_data, e.d);
                        check_bit("a_first", a_out_first, e.f);
                        check_bit("a_last", a_out_last, e.l);
                        a_pops++;
                        $display("A word k=%0d data=%0h", e.k, a_out_data);
                    end
                end else if (!a_out_valid) begin
                    check_word("a_idle_data", a_out_data, 34'd0);
                    check_bit("a_idle_first", a_out_first, 1'b0);
                    check_bit("a_idle_last", a_out_last, 1'b0);
                end
                hold   = a_out_valid && !a_out_ready;
                hold_d = a_out_data;
            end
        end
    end

    initial begin : mon_b
        logic        hold;
        logic [33:0] hold_d;
        exp_t        e;
        hold   = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!b_rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check_bit("b_hold_valid", b_out_valid, 1'b1);
                    check_word("b_hold_data", 34'(b_out_data), hold_d);
                end
                if (b_out_valid && b_out_ready) begin
                    if (q_b.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL b_extra_word actual=%0h required=no_word", b_out_data);
                    end else begin
                        e = q_b.pop_front();
                        check_word("b_data", 34'(b_out_data), e.d);
                        check_bit("b_first", b_out_first, e.f);
                        check_bit("b_last", b_out_last, e.l);
                        b_pops++;
                        $display("B word k=%0d data=%0h", e.k, b_out_data);
                    end
                end else if (!b_out_valid) begin
                    check_word("b_idle_data", 34'(b_out_data), 34'd0);
                    check_bit("b_idle_first", b_out_first, 1'b0);
                    check_bit("b_idle_last", b_out_last, 1'b0);
                end
                hold   = b_out_valid && !b_out_ready;
                hold_d = 34'(b_out_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [33:0] w [NW];
        logic        ok;
        int          pp_base;

        a_rst_n = 1'b0; a_clr = 1'b0; a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0;
        b_rst_n = 1'b0; b_clr = 1'b0; b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit("reset_in_ready", in_rdy(d), 1'b1);
            check_bit("reset_out_valid", o_valid(d), 1'b0);
            check_bit("reset_out_first", o_first(d), 1'b0);
            check_bit("reset_out_last", o_last(d), 1'b0);
            check_word("reset_out_data", o_data(d), 34'd0);
        end
        @(posedge clk);
        #2;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counting pattern, beat-major then lane-major.
        for (int b = 0; b < AB; b++)
            for (int l = 0; l < AL; l++)
                w[b*AL + l] = 34'(16*b + l);
        send_frame(0, w, 1'b0);
        check_bit("latency_valid", a_out_valid, 1'b1);
        check_bit("latency_first", a_out_first, 1'b1);
        check_word("latency_data", a_out_data, 34'd0);
        wait_drain(0);
        send_frame(0, w, 1'b1);
        check_word("lane_major_first_data", a_out_data, 34'd0);
        wait_drain(0);

        // Ping-pong: three frames back to back.
        pp_base = a_pops;
        for (int f = 0; f < 3; f++) begin
            rand_words(0, w);
            send_frame(0, w, 1'($urandom_range(0, 1)));
            if (f == 1) check_bit("pp_in_ready_low", a_in_ready, 1'b0);
            if (f == 2) check_bit("pp_frame3_after_drain", (last_first_pops - pp_base) >= 16, 1'b1);
        end
        wait_drain(0);
        check_bit("pp_word_count", (a_pops - pp_base) == 48, 1'b1);

        // Random backpressure.
        a_rdy_mode = 2;
        for (int f = 0; f < 3; f++) begin
            rand_words(0, w);
            send_frame(0, w, 1'($urandom_range(0, 1)));
        end
        wait_drain(0);
        a_rdy_mode = 1;

        // One more frame so the write bank pointer is on bank 1 before clr.
        rand_words(0, w);
        send_frame(0, w, 1'b1);
        wait_drain(0);

        // clr after two beats, with a third beat presented during clr.
        rand_words(0, w);
        send_beat(0, w, 0, 1'b0, ok);
        send_beat(0, w, 1, 1'b0, ok);
        drive_beat(0, 1'b1, w, 2, 1'b0);
        a_clr = 1'b1;
        @(negedge clk);
        check_bit("clr_in_ready_shown", a_in_ready, 1'b1);
        @(posedge clk);
        #1;
        a_clr      = 1'b0;
        a_in_valid = 1'b0;
        check_bit("clr_in_ready", a_in_ready, 1'b1);
        check_bit("clr_out_valid", a_out_valid, 1'b0);
        rand_words(0, w);
        send_frame(0, w, 1'b1);
        wait_drain(0);

        reset_mid_drain(0, 1'b0);

        // Second geometry: W=8, LANES=2, BEATS=8.
        rand_words(1, w);
        send_frame(1, w, 1'b1);
        check_bit("b_latency_valid", b_out_valid, 1'b1);
        wait_drain(1);
        b_rdy_mode = 2;
        for (int f = 0; f < 2; f++) begin
            rand_words(1, w);
            send_frame(1, w, 1'(f));
        end
        wait_drain(1);
        b_rdy_mode = 1;
        reset_mid_drain(1, 1'b1);

        check_bit("a_queue_empty", q_a.size() == 0, 1'b1);
        check_bit("b_queue_empty", q_b.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_p_s_param
